// File: rtl/vec_alu_sequencer.sv
// vec_alu_sequencer
//   Walks a packed operand vector pair one element per clock through an
//   external combinational element ALU and collects the per-element results
//   into a packed result vector. One operation is in flight at a time.
//
// Ports
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid / in_ready   : request handshake (in_ready only while IDLE)
//   in_op, in_len         : ALU select code and active element count
//   in_vec_a, in_vec_b    : packed operands, element i at [i*ELEMENT +: ELEMENT]
//   alu_sel, alu_a, alu_b : drive to the external element ALU (zero outside RUN)
//   alu_result            : combinational ALU result for the current drive
//   out_valid / out_ready : result handshake, out_vec held stable while waiting
//   out_vec               : packed result vector, same packing as the operands
//   busy                  : high whenever the sequencer is not IDLE
module vec_alu_sequencer #(
  parameter int ELEMENT = 16,
  parameter int LANES   = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2:0]                 in_op,
  input  logic [3:0]                 in_len,
  input  logic [LANES*ELEMENT-1:0]   in_vec_a,
  input  logic [LANES*ELEMENT-1:0]   in_vec_b,
  output logic [2:0]                 alu_sel,
  output logic [ELEMENT-1:0]         alu_a,
  output logic [ELEMENT-1:0]         alu_b,
  input  logic [ELEMENT-1:0]         alu_result,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [LANES*ELEMENT-1:0]   out_vec,
  output logic                       busy
);

  localparam int VEC_W = LANES * ELEMENT;
  // Wide enough to hold LANES itself, since the length register may equal it.
  localparam int IDX_W = $clog2(LANES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic [VEC_W-1:0]   a_q, a_d;
  logic [VEC_W-1:0]   b_q, b_d;
  logic [VEC_W-1:0]   res_q, res_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [IDX_W-1:0]   len_q, len_d;
  logic [IDX_W-1:0]   eff_len;
  logic               accept;

  // Requests longer than the vector are clamped to the full vector.
  always_comb begin
    if (int'(in_len) > LANES) begin
      eff_len = IDX_W'(LANES);
    end else begin
      eff_len = IDX_W'(in_len);
    end
  end

  // Gating with rst keeps in_ready low for the whole reset window.
  assign in_ready  = (state_q == IDLE) && !rst;
  assign accept    = in_valid && in_ready;
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign out_vec   = res_q;

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    idx_d   = idx_q;
    len_d   = len_q;
    alu_sel = '0;
    alu_a   = '0;
    alu_b   = '0;

    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d  = in_op;
          a_d   = in_vec_a;
          b_d   = in_vec_b;
          res_d = '0;
          idx_d = '0;
          len_d = eff_len;
          state_d = (eff_len == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        alu_sel = op_q;
        alu_a   = a_q[idx_q*ELEMENT +: ELEMENT];
        alu_b   = b_q[idx_q*ELEMENT +: ELEMENT];
        res_d[idx_q*ELEMENT +: ELEMENT] = alu_result;
        idx_d = idx_q + 1'b1;
        // idx_d reaching the length means this cycle captures the last element.
        if (idx_d == len_q) begin
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      idx_q   <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
    end
  end

endmodule

// File: doc/vec_alu_sequencer.md
VEC_ALU_SEQUENCER -- requirements
Module: vec_alu_sequencer

Interface
REQ-001 Parameter ELEMENT, default 16, SHALL set the element width in bits.
REQ-002 Parameter LANES, default 8, SHALL set the number of elements per vector.
REQ-003 Port clk, input, 1, SHALL be the single clock; all state updates on its rising edge.
REQ-004 Port rst, input, 1, SHALL be the asynchronous, active-high reset.
REQ-005 Port in_valid, input, 1, SHALL flag a vector operation request.
REQ-006 Port in_ready, output, 1, SHALL flag that a request is accepted this cycle.
REQ-007 Port in_op, input, 3, SHALL carry the ALU select code (000 add, 001 sub, 010 mul, 011/100 shift right, 101 shift left, 110 and, 111 reserved).
REQ-008 Port in_len, input, 4, SHALL carry the active element count.
REQ-009 Ports in_vec_a and in_vec_b, input, LANES*ELEMENT, SHALL carry packed operand vectors; element i occupies bits [i*ELEMENT +: ELEMENT].
REQ-010 Port alu_sel, output, 3, SHALL drive the element ALU select code.
REQ-011 Ports alu_a and alu_b, output, ELEMENT, SHALL drive the element ALU operands.
REQ-012 Port alu_result, input, ELEMENT, SHALL return the combinational ALU result for the current alu_sel/alu_a/alu_b.
REQ-013 Port out_valid, output, 1, SHALL flag a completed result vector.
REQ-014 Port out_ready, input, 1, SHALL flag that the consumer accepts the result.
REQ-015 Port out_vec, output, LANES*ELEMENT, SHALL carry the packed result vector, same packing as the inputs.
REQ-016 Port busy, output, 1, SHALL be high whenever the state is not IDLE.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, RUN, DONE.
REQ-018 in_ready SHALL be high only in IDLE; a request is accepted on a rising edge with in_valid and in_ready both high.
REQ-019 On acceptance, the block SHALL register in_op and both operand vectors, clear the result register to zero, and set the element index to 0.
REQ-020 On acceptance, the effective length SHALL be min(in_len, LANES).
REQ-021 If the effective length is 0, the next state SHALL be DONE; otherwise it SHALL be RUN.
REQ-022 In RUN, alu_sel SHALL equal the registered op, and alu_a and alu_b SHALL equal registered element [index] of A and B respectively.
REQ-023 In RUN, each clock SHALL write alu_result into result element [index] and then increment the index.
REQ-024 When index equals effective length - 1 in RUN, the next state SHALL be DONE.
REQ-025 RUN SHALL last exactly effective-length cycles; out_valid SHALL assert in the cycle after the last capture.
REQ-026 Outside RUN, alu_sel, alu_a and alu_b SHALL be 0.
REQ-027 Result elements at indices >= the effective length SHALL be 0.
REQ-028 In DONE, out_valid SHALL be high, and out_vec SHALL be stable until the handshake completes.
REQ-029 On a DONE cycle with out_ready high, the next state SHALL be IDLE.
REQ-030 A new request SHALL NOT be accepted in the same cycle as the out handshake.
REQ-031 Minimum spacing between consecutive acceptances SHALL be effective length + 2 cycles.
REQ-032 Arithmetic SHALL be performed solely by the external element ALU; results SHALL be truncated to ELEMENT bits, and the sequencer SHALL NOT modify them.
REQ-033 in_op 111 SHALL be forwarded unchanged; the sequencer SHALL store whatever alu_result returns.
REQ-034 in_valid asserted while busy SHALL be ignored and SHALL NOT corrupt state.

Reset
REQ-035 While rst is high, the state SHALL be IDLE, and the index, registered operands, op and out_vec SHALL be 0.
REQ-036 While rst is high, out_valid SHALL be 0, in_ready SHALL be 0, busy SHALL be 0, and alu_sel, alu_a and alu_b SHALL be 0.
REQ-037 Reset asserted mid-RUN or in DONE SHALL abort the operation immediately; the partial result SHALL be discarded and no out_valid SHALL follow.
REQ-038 in_ready SHALL rise in the first cycle after rst deasserts.

Verification
REQ-039 Full-length add: op=000, len=8, A[i]=i+1, B[i]=0x0010 -> 8 RUN cycles, out_valid in cycle 9, out_vec[i]=0x0011+i.
REQ-040 Partial sub: op=001, len=3, A[i]=0x0005, B[i]=0x0007 -> out_vec[0..2]=0xFFFE, out_vec[3..7]=0, alu_* go to 0 after 3 cycles.
REQ-041 Zero and overlong length: len=0 -> out_valid in the next cycle with out_vec all zero; len=12 -> behaves as len=8.
REQ-042 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and out_vec stay constant, in_ready stays 0, and an in_valid pulse is ignored.
REQ-043 Reset mid-RUN: assert rst at index 4 of a len=8 mul -> all outputs 0 within the same cycle, and in_ready=1 the first cycle after release.
REQ-044 Back-to-back: two requests with in_valid held high -> the second is accepted exactly one cycle after the first out handshake, with correct independent results.
